// File: rtl/riscv_fetch_aligner.sv
// RISC-V fetch aligner: splits fetch blocks into a circular halfword buffer and
// presents one aligned 16- or 32-bit instruction per handshake with its PC.
module riscv_fetch_aligner #(
    parameter int          FETCH_W   = 64,
    parameter int          BUF_DEPTH = 8,
    parameter logic [31:0] RESET_PC  = 32'h8000_0000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic [31:0]        flush_pc_i,
    input  logic               fetch_valid_i,
    output logic               fetch_ready_o,
    input  logic [31:0]        fetch_pc_i,
    input  logic [FETCH_W-1:0] fetch_data_i,
    input  logic               fetch_err_i,
    output logic               instr_valid_o,
    input  logic               instr_ready_i,
    output logic [31:0]        instr_o,
    output logic [31:0]        instr_pc_o,
    output logic               instr_is_comp_o,
    output logic               instr_err_o
);
    localparam int NHW = FETCH_W / 16;
    localparam int PW  = $clog2(BUF_DEPTH);
    localparam int SKW = $clog2(NHW);
    localparam int CW  = PW + 1;

    logic [15:0]    r_hw_data [BUF_DEPTH];
    logic           r_hw_err  [BUF_DEPTH];
    logic [PW-1:0]  r_rd;
    logic [PW-1:0]  r_wr;
    logic [CW-1:0]  r_cnt;
    logic [SKW-1:0] r_skip;
    logic [31:0]    r_pc;

    logic [PW-1:0]  w_rd1;
    logic [15:0]    w_head;
    logic [15:0]    w_next;
    logic           w_comp;
    logic           w_valid;
    logic           w_push;
    logic           w_pop;
    logic [CW-1:0]  w_npush;
    logic [CW-1:0]  w_npop;
    logic [CW-1:0]  w_free;

    assign w_rd1   = r_rd + PW'(1);
    assign w_head  = r_hw_data[r_rd];
    assign w_next  = r_hw_data[w_rd1];
    assign w_comp  = (w_head[1:0] != 2'b11);
    assign w_free  = CW'(BUF_DEPTH) - r_cnt;
    assign w_npush = CW'(NHW) - CW'(r_skip);
    assign w_npop  = w_comp ? CW'(1) : CW'(2);
    assign w_push  = fetch_valid_i & fetch_ready_o;
    assign w_pop   = w_valid & instr_ready_i;

    // Head decode and fetch-side flow control, all from buffer registers.
    always_comb begin
        w_valid         = 1'b0;
        fetch_ready_o   = 1'b0;
        instr_o         = 32'h0000_0000;
        instr_is_comp_o = w_comp;
        instr_err_o     = 1'b0;
        instr_pc_o      = r_pc;
        if (r_cnt == CW'(0)) begin
            w_valid = 1'b0;
        end else if (w_comp) begin
            w_valid = 1'b1;
        end else begin
            w_valid = (r_cnt >= CW'(2));
        end
        if (w_comp) begin
            instr_o     = {16'h0000, w_head};
            instr_err_o = w_valid & r_hw_err[r_rd];
        end else begin
            instr_o     = {w_next, w_head};
            instr_err_o = w_valid & (r_hw_err[r_rd] | r_hw_err[w_rd1]);
        end
        // A same-cycle pop earns no credit, keeping ready independent of instr_ready_i.
        if (rst_i || flush_i) begin
            fetch_ready_o = 1'b0;
        end else begin
            fetch_ready_o = (w_free >= CW'(NHW));
        end
        instr_valid_o = w_valid;
    end

    // Pointer, count, skip and PC bookkeeping; reset beats flush beats handshakes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd   <= '0;
            r_wr   <= '0;
            r_cnt  <= '0;
            r_skip <= RESET_PC[SKW:1];
            r_pc   <= RESET_PC;
        end else if (flush_i) begin
            r_rd   <= '0;
            r_wr   <= '0;
            r_cnt  <= '0;
            r_skip <= flush_pc_i[SKW:1];
            r_pc   <= flush_pc_i;
        end else begin
            if (w_push) begin
                r_wr   <= r_wr + PW'(w_npush);
                r_skip <= '0;
            end
            if (w_pop) begin
                r_rd <= r_rd + PW'(w_npop);
                r_pc <= r_pc + (w_comp ? 32'd2 : 32'd4);
            end
            r_cnt <= r_cnt + (w_push ? w_npush : CW'(0)) - (w_pop ? w_npop : CW'(0));
        end
    end

    // Halfword storage: accepted block written from the skip index upward.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_hw_data[i] <= 16'h0000;
                r_hw_err[i]  <= 1'b0;
            end
        end else if (w_push) begin
            for (int i = 0; i < NHW; i++) begin
                if (i >= int'(r_skip)) begin
                    r_hw_data[r_wr + PW'(i) - PW'(r_skip)] <= fetch_data_i[16*i +: 16];
                    r_hw_err[r_wr + PW'(i) - PW'(r_skip)]  <= fetch_err_i;
                end
            end
        end
    end

    riscv_fetch_aligner_chk #(.FETCH_W(FETCH_W)) u_chk (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .flush_i       (flush_i),
        .flush_pc_i    (flush_pc_i),
        .fetch_valid_i (fetch_valid_i),
        .fetch_ready_i (fetch_ready_o),
        .fetch_pc_i    (fetch_pc_i)
    );
endmodule

// Simulation check: the first block accepted after a flush must carry the
// block-aligned flush target address.
module riscv_fetch_aligner_chk #(
    parameter int FETCH_W = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    input  logic        fetch_valid_i,
    input  logic        fetch_ready_i,
    input  logic [31:0] fetch_pc_i
);
    localparam logic [31:0] ALIGN_MASK = ~(32'(FETCH_W / 8) - 32'd1);

    logic        r_armed;
    logic [31:0] r_exp_pc;

    // Arm on flush, compare on the next accepted block, then disarm.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_armed  <= 1'b0;
            r_exp_pc <= 32'h0000_0000;
        end else if (flush_i) begin
            r_armed  <= 1'b1;
            r_exp_pc <= flush_pc_i & ALIGN_MASK;
        end else if (fetch_valid_i && fetch_ready_i && r_armed) begin
            assert (fetch_pc_i == r_exp_pc);
            r_armed <= 1'b0;
        end else begin
            r_armed <= r_armed;
        end
    end
endmodule

// File: tb/tb_riscv_fetch_aligner.sv
// Directed self-checking bench for riscv_fetch_aligner with 32-bit fetch blocks.
module tb_riscv_fetch_aligner;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic [31:0] flush_pc_i = 32'h0;
    logic        fetch_valid_i = 1'b0;
    logic        fetch_ready_o;
    logic [31:0] fetch_pc_i = 32'h0;
    logic [31:0] fetch_data_i = 32'h0;
    logic        fetch_err_i = 1'b0;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_is_comp_o;
    logic        instr_err_o;

    int errors = 0;
    int checks = 0;

    riscv_fetch_aligner #(.FETCH_W(32), .BUF_DEPTH(8), .RESET_PC(32'h8000_0000)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .flush_i         (flush_i),
        .flush_pc_i      (flush_pc_i),
        .fetch_valid_i   (fetch_valid_i),
        .fetch_ready_o   (fetch_ready_o),
        .fetch_pc_i      (fetch_pc_i),
        .fetch_data_i    (fetch_data_i),
        .fetch_err_i     (fetch_err_i),
        .instr_valid_o   (instr_valid_o),
        .instr_ready_i   (instr_ready_i),
        .instr_o         (instr_o),
        .instr_pc_o      (instr_pc_o),
        .instr_is_comp_o (instr_is_comp_o),
        .instr_err_o     (instr_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Head fields packed as {valid, instr, pc, comp, err}.
    task automatic check_head(input string name, input logic [66:0] exp);
        logic [66:0] got;
        got = {instr_valid_o, instr_o, instr_pc_o, instr_is_comp_o, instr_err_o};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got {v,instr,pc,comp,err}=%h expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick();
        tick();
        checks++; if (fetch_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %b expected 0", fetch_ready_o); end
        rst_i = 1'b0;
        #1;
        checks++; if ({instr_valid_o, instr_pc_o, instr_err_o} !== {1'b0, 32'h8000_0000, 1'b0}) begin errors++; $display("FAIL reset_state: got v=%b pc=%h err=%b expected 0/80000000/0", instr_valid_o, instr_pc_o, instr_err_o); end
        checks++; if (fetch_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b expected 1", fetch_ready_o); end
    endtask

    task automatic test_compressed();
        fetch_valid_i = 1'b1; fetch_pc_i = 32'h8000_0000; fetch_data_i = 32'h0505_4501;
        #1;
        checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL comp_latency: got valid=%b expected 0", instr_valid_o); end
        tick();
        fetch_valid_i = 1'b0;
        check_head("comp_first", {1'b1, 32'h0000_4501, 32'h8000_0000, 1'b1, 1'b0});
        instr_ready_i = 1'b1;
        tick();
        check_head("comp_second", {1'b1, 32'h0000_0505, 32'h8000_0002, 1'b1, 1'b0});
        tick();
        instr_ready_i = 1'b0;
        checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL comp_empty: got valid=%b expected 0", instr_valid_o); end
    endtask

    task automatic test_spanning();
        fetch_valid_i = 1'b1; fetch_pc_i = 32'h8000_0004; fetch_data_i = 32'h0513_4501;
        tick();
        fetch_valid_i = 1'b0;
        check_head("span_first", {1'b1, 32'h0000_4501, 32'h8000_0004, 1'b1, 1'b0});
        instr_ready_i = 1'b1;
        tick();
        checks++; if ({instr_valid_o, instr_is_comp_o} !== 2'b00) begin errors++; $display("FAIL span_wait: got v=%b comp=%b expected 0/0", instr_valid_o, instr_is_comp_o); end
        fetch_valid_i = 1'b1; fetch_pc_i = 32'h8000_0008; fetch_data_i = 32'h0000_0010;
        tick();
        fetch_valid_i = 1'b0;
        check_head("span_whole", {1'b1, 32'h0010_0513, 32'h8000_0006, 1'b0, 1'b0});
        tick();
        check_head("span_next_pc", {1'b1, 32'h0000_0000, 32'h8000_000A, 1'b1, 1'b0});
        tick();
        instr_ready_i = 1'b0;
        checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL span_empty: got valid=%b expected 0", instr_valid_o); end
    endtask

    task automatic test_flush();
        flush_i = 1'b1; flush_pc_i = 32'h0000_2002;
        #1;
        checks++; if (fetch_ready_o !== 1'b0) begin errors++; $display("FAIL flush_ready_low: got %b expected 0", fetch_ready_o); end
        tick();
        flush_i = 1'b0;
        checks++; if ({instr_valid_o, instr_pc_o} !== {1'b0, 32'h0000_2002}) begin errors++; $display("FAIL flush_state: got v=%b pc=%h expected 0/00002002", instr_valid_o, instr_pc_o); end
        fetch_valid_i = 1'b1; fetch_pc_i = 32'h0000_2000; fetch_data_i = 32'h4585_4501;
        tick();
        fetch_valid_i = 1'b0;
        check_head("flush_skip", {1'b1, 32'h0000_4585, 32'h0000_2002, 1'b1, 1'b0});
        instr_ready_i = 1'b1;
        tick();
        instr_ready_i = 1'b0;
        checks++; if ({instr_valid_o, instr_pc_o} !== {1'b0, 32'h0000_2004}) begin errors++; $display("FAIL flush_dropped: got v=%b pc=%h expected 0/00002004", instr_valid_o, instr_pc_o); end
    endtask

    task automatic test_backpressure();
        logic [15:0] hw;
        for (int k = 0; k < 4; k++) begin
            fetch_valid_i = 1'b1;
            fetch_pc_i    = 32'h0000_2004 + 32'(4 * k);
            fetch_data_i  = {16'h1000 + 16'(8 * k + 4), 16'h1000 + 16'(8 * k)};
            #1;
            checks++; if (fetch_ready_o !== 1'b1) begin errors++; $display("FAIL bp_ready_fill%0d: got %b expected 1", k, fetch_ready_o); end
            tick();
        end
        fetch_pc_i = 32'h0000_2014; fetch_data_i = 32'h4444_4444;
        checks++; if (fetch_ready_o !== 1'b0) begin errors++; $display("FAIL bp_full: got ready=%b expected 0", fetch_ready_o); end
        check_head("bp_head", {1'b1, 32'h0000_1000, 32'h0000_2004, 1'b1, 1'b0});
        tick();
        tick();
        check_head("bp_stable", {1'b1, 32'h0000_1000, 32'h0000_2004, 1'b1, 1'b0});
        fetch_valid_i = 1'b0;
        instr_ready_i = 1'b1;
        tick();
        instr_ready_i = 1'b0;
        checks++; if (fetch_ready_o !== 1'b0) begin errors++; $display("FAIL bp_one_free: got ready=%b expected 0", fetch_ready_o); end
        check_head("bp_pop1", {1'b1, 32'h0000_1004, 32'h0000_2006, 1'b1, 1'b0});
        instr_ready_i = 1'b1;
        tick();
        checks++; if (fetch_ready_o !== 1'b1) begin errors++; $display("FAIL bp_two_free: got ready=%b expected 1", fetch_ready_o); end
        for (int j = 2; j < 8; j++) begin
            hw = 16'h1000 + 16'(4 * j);
            check_head($sformatf("bp_drain%0d", j), {1'b1, 16'h0000, hw, 32'h0000_2004 + 32'(2 * j), 1'b1, 1'b0});
            tick();
        end
        instr_ready_i = 1'b0;
        checks++; if ({instr_valid_o, instr_pc_o} !== {1'b0, 32'h0000_2014}) begin errors++; $display("FAIL bp_empty: got v=%b pc=%h expected 0/00002014", instr_valid_o, instr_pc_o); end
    endtask

    task automatic test_error();
        logic [31:0] blk_pc   [3] = '{32'h0000_2014, 32'h0000_2018, 32'h0000_201C};
        logic [31:0] blk_data [3] = '{32'h0513_4501, 32'h4585_0010, 32'h4601_4681};
        logic        blk_err  [3] = '{1'b0, 1'b1, 1'b0};
        logic [66:0] exp      [5] = '{{1'b1, 32'h0000_4501, 32'h0000_2014, 1'b1, 1'b0},
                                      {1'b1, 32'h0010_0513, 32'h0000_2016, 1'b0, 1'b1},
                                      {1'b1, 32'h0000_4585, 32'h0000_201A, 1'b1, 1'b1},
                                      {1'b1, 32'h0000_4681, 32'h0000_201C, 1'b1, 1'b0},
                                      {1'b1, 32'h0000_4601, 32'h0000_201E, 1'b1, 1'b0}};
        for (int k = 0; k < 3; k++) begin
            fetch_valid_i = 1'b1; fetch_pc_i = blk_pc[k]; fetch_data_i = blk_data[k]; fetch_err_i = blk_err[k];
            tick();
        end
        fetch_valid_i = 1'b0; fetch_err_i = 1'b0;
        instr_ready_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check_head($sformatf("err_instr%0d", k), exp[k]);
            tick();
        end
        instr_ready_i = 1'b0;
        checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL err_once: got valid=%b expected 0", instr_valid_o); end
    endtask

    task automatic test_flush_and_reset();
        fetch_valid_i = 1'b1; fetch_pc_i = 32'h0000_2020; fetch_data_i = 32'h4501_4501;
        tick();
        flush_i = 1'b1; flush_pc_i = 32'h0000_3000;
        fetch_pc_i = 32'h0000_2024; fetch_data_i = 32'h4601_4601;
        instr_ready_i = 1'b1;
        tick();
        flush_i = 1'b0; fetch_valid_i = 1'b0; instr_ready_i = 1'b0;
        checks++; if ({instr_valid_o, instr_pc_o} !== {1'b0, 32'h0000_3000}) begin errors++; $display("FAIL coll_flush: got v=%b pc=%h expected 0/00003000", instr_valid_o, instr_pc_o); end
        tick();
        checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL coll_no_stale: got valid=%b expected 0", instr_valid_o); end
        fetch_valid_i = 1'b1; fetch_pc_i = 32'h0000_3000; fetch_data_i = 32'h0513_4501;
        tick();
        fetch_valid_i = 1'b0; instr_ready_i = 1'b1;
        tick();
        instr_ready_i = 1'b0;
        checks++; if ({instr_valid_o, instr_is_comp_o, instr_pc_o} !== {1'b0, 1'b0, 32'h0000_3002}) begin errors++; $display("FAIL midspan: got v=%b comp=%b pc=%h expected 0/0/00003002", instr_valid_o, instr_is_comp_o, instr_pc_o); end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        #1;
        checks++; if ({instr_valid_o, instr_pc_o, instr_err_o, fetch_ready_o} !== {1'b0, 32'h8000_0000, 1'b0, 1'b1}) begin errors++; $display("FAIL midspan_reset: got v=%b pc=%h err=%b rdy=%b expected 0/80000000/0/1", instr_valid_o, instr_pc_o, instr_err_o, fetch_ready_o); end
        fetch_valid_i = 1'b1; fetch_pc_i = 32'h8000_0000; fetch_data_i = 32'h4585_4501;
        tick();
        fetch_valid_i = 1'b0;
        check_head("post_reset_first", {1'b1, 32'h0000_4501, 32'h8000_0000, 1'b1, 1'b0});
        instr_ready_i = 1'b1;
        tick();
        check_head("post_reset_second", {1'b1, 32'h0000_4585, 32'h8000_0002, 1'b1, 1'b0});
        tick();
        instr_ready_i = 1'b0;
        checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL post_reset_empty: got valid=%b expected 0", instr_valid_o); end
    endtask

    initial begin
        test_reset();
        test_compressed();
        test_spanning();
        test_flush();
        test_backpressure();
        test_error();
        test_flush_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
